// File: rtl/serial_receiver_pkg.sv
// Shared frame-format definitions for the serial link (receiver and transmitter).
package serial_receiver_pkg;

  // Default number of data bits carried by one frame.
  localparam int DEFAULT_WIDTH = 8;

  // Receiver/transmitter frame-phase encoding; both ends agree on these values.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // Counter width able to hold the values 0..w.
  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_shift_in.sv
// Data-bit shift register and bit counter for the serial receiver.
// clr has priority over shift_en; last_bit flags the tick that completes the word.
module serial_shift_in
  import serial_receiver_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic             last_bit
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  // Per-bit next value: MSB-first shifts left (new bit at LSB),
  // LSB-first shifts right (new bit at MSB).
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_in
          assign word_d[gi] = bit_in;
        end else begin : g_mv
          assign word_d[gi] = word_q[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_in
          assign word_d[gi] = bit_in;
        end else begin : g_mv
          assign word_d[gi] = word_q[gi+1];
        end
      end
    end
  endgenerate

  assign cnt_d = cnt_q + CW'(1);

  // Shift register and counter: cleared at the start bit, advanced on data ticks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift_en) begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word     = word_q;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_receiver.sv
// Framed serial receiver: start / data / optional parity / stop, sampled on enable ticks.
// Good words are held on qout with a valid/ack handshake; errors are sticky flags.
module serial_receiver
  import serial_receiver_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             serialin,
  input  logic             ack,
  output logic [WIDTH-1:0] qout,
  output logic             valid,
  output logic             co,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  rx_state_t        state_q;
  logic [WIDTH-1:0] qout_q;
  logic             valid_q;
  logic             co_q;
  logic             frame_err_q;
  logic             parity_err_q;
  logic             overrun_q;
  logic             par_bad_q;

  logic [WIDTH-1:0] word;
  logic             last_bit;
  logic             shift_en;
  logic             clr;
  logic             stop_tick;
  logic             valid_hold;
  logic             frame_good;
  logic             par_calc_bad;

  assign shift_en  = enable && (state_q == DATA);
  assign clr       = enable && (state_q == IDLE) && !serialin;
  assign stop_tick = enable && (state_q == STOP);

  // valid after this edge's handshake, before any new word is considered;
  // an ack on the completion edge frees the slot so the new word can load.
  assign valid_hold = valid_q && !ack;

  // Data bits XOR parity bit must equal 1 for odd parity, 0 for even.
  assign par_calc_bad = ((^word) ^ serialin) != PARITY_ODD;

  // A frame is good when its stop bit is high and its parity (if any) matched.
  assign frame_good = serialin && !par_bad_q;

  serial_shift_in #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clock   (clock),
    .reset   (reset),
    .shift_en(shift_en),
    .clr     (clr),
    .bit_in  (serialin),
    .word    (word),
    .last_bit(last_bit)
  );

  // Frame FSM with registered word, handshake, completion pulse and sticky error flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      qout_q       <= '0;
      valid_q      <= 1'b0;
      co_q         <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      par_bad_q    <= 1'b0;
    end else begin
      co_q    <= stop_tick;
      valid_q <= valid_hold;
      if (enable) begin
        case (state_q)
          IDLE: begin
            if (!serialin) begin
              state_q   <= DATA;
              par_bad_q <= 1'b0;
            end
          end
          DATA: begin
            if (last_bit) begin
              state_q <= PARITY_EN ? PARITY : STOP;
            end
          end
          PARITY: begin
            par_bad_q <= par_calc_bad;
            state_q   <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!serialin) begin
              frame_err_q <= 1'b1;
            end
            if (par_bad_q) begin
              parity_err_q <= 1'b1;
            end
            if (frame_good) begin
              if (!valid_hold) begin
                qout_q  <= word;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign qout       = qout_q;
  assign valid      = valid_q;
  assign co         = co_q;
  assign busy       = (state_q != IDLE);
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver: three instances (MSB-first no parity,
// MSB-first even parity, LSB-first odd parity) driven with the same words.
module tb_serial_receiver;

  logic       clock = 1'b0;
  logic       reset;
  logic       en    [3];
  logic       ser   [3];
  logic       ack   [3];
  logic [7:0] qout  [3];
  logic       valid [3];
  logic       co    [3];
  logic       busy  [3];
  logic       fe    [3];
  logic       pe    [3];
  logic       ov    [3];
  logic       co_prev [3];

  typedef struct packed {
    logic [7:0] q;
    logic       v;
    logic       fe;
    logic       pe;
    logic       ov;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];
  exp_t mdl[3];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  serial_receiver #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
    .clock(clock), .reset(reset), .enable(en[0]), .serialin(ser[0]), .ack(ack[0]),
    .qout(qout[0]), .valid(valid[0]), .co(co[0]), .busy(busy[0]),
    .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]));

  serial_receiver #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
    .clock(clock), .reset(reset), .enable(en[1]), .serialin(ser[1]), .ack(ack[1]),
    .qout(qout[1]), .valid(valid[1]), .co(co[1]), .busy(busy[1]),
    .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]));

  serial_receiver #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_c (
    .clock(clock), .reset(reset), .enable(en[2]), .serialin(ser[2]), .ack(ack[2]),
    .qout(qout[2]), .valid(valid[2]), .co(co[2]), .busy(busy[2]),
    .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ov[2]));

  function automatic bit p_msbf(input int k);
    return (k != 2);
  endfunction

  function automatic bit p_pen(input int k);
    return (k != 0);
  endfunction

  function automatic bit p_odd(input int k);
    return (k == 2);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic sb_push(input int k, input exp_t e);
    case (k)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  // Compare every completed frame against the scoreboard when co pulses.
  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (co[k] === 1'b1) begin
        int   sz;
        exp_t e;
        check_eq($sformatf("co_one_cycle[%0d]", k), co_prev[k], 0);
        case (k)
          0:       sz = sb0.size();
          1:       sz = sb1.size();
          default: sz = sb2.size();
        endcase
        check_eq($sformatf("sb_has_entry[%0d]", k), (sz > 0), 1);
        if (sz > 0) begin
          case (k)
            0:       e = sb0.pop_front();
            1:       e = sb1.pop_front();
            default: e = sb2.pop_front();
          endcase
          check_eq($sformatf("qout[%0d]", k), qout[k], e.q);
          check_eq($sformatf("valid[%0d]", k), valid[k], e.v);
          check_eq($sformatf("frame_err[%0d]", k), fe[k], e.fe);
          check_eq($sformatf("parity_err[%0d]", k), pe[k], e.pe);
          check_eq($sformatf("overrun[%0d]", k), ov[k], e.ov);
        end
        $display("frame dut%0d: qout=%02h valid=%0b fe=%0b pe=%0b ov=%0b",
                 k, qout[k], valid[k], fe[k], pe[k], ov[k]);
      end
      co_prev[k] = co[k];
    end
  end

  // Drive one frame (or its first 'cut' bits) into instance k; full frames go to the scoreboard.
  task automatic send_one(input int k, input logic [7:0] word, input bit bad_par,
                          input bit stop_bit, input bit ack_stop, input int gap, input int cut);
    logic bits[$];
    int   nb;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(p_msbf(k) ? word[7-i] : word[i]);
    end
    if (p_pen(k)) begin
      bits.push_back((^word) ^ p_odd(k) ^ bad_par);
    end
    bits.push_back(stop_bit);
    nb = (cut > 0) ? cut : bits.size();

    if (cut <= 0) begin
      exp_t m;
      logic vh;
      logic bad;
      m   = mdl[k];
      vh  = m.v & ~ack_stop;
      bad = p_pen(k) & bad_par;
      if (!stop_bit) m.fe = 1'b1;
      if (bad)       m.pe = 1'b1;
      m.v = vh;
      if (stop_bit && !bad) begin
        if (!vh) begin
          m.q = word;
          m.v = 1'b1;
        end else begin
          m.ov = 1'b1;
        end
      end
      mdl[k] = m;
      sb_push(k, m);
    end

    for (int i = 0; i < nb; i++) begin
      repeat (gap) begin
        en[k]  = 1'b0;
        ser[k] = ~bits[i];
        @(posedge clock); #1;
      end
      en[k]  = 1'b1;
      ser[k] = bits[i];
      ack[k] = ack_stop && (i == bits.size() - 1);
      @(posedge clock); #1;
      ack[k] = 1'b0;
      en[k]  = 1'b0;
      ser[k] = 1'b1;
      if (i == 0) check_eq($sformatf("busy_in_frame[%0d]", k), busy[k], 1);
    end
    if (cut <= 0) check_eq($sformatf("busy_after_stop[%0d]", k), busy[k], 0);
  endtask

  task automatic send_all(input logic [7:0] word, input bit bad_par, input bit stop_bit,
                          input bit ack_stop, input int gap);
    fork
      send_one(0, word, bad_par, stop_bit, ack_stop, gap, 0);
      send_one(1, word, bad_par, stop_bit, ack_stop, gap, 0);
      send_one(2, word, bad_par, stop_bit, ack_stop, gap, 0);
    join
  endtask

  // Pulse ack for one cycle on every instance; valid must drop, word must stay.
  task automatic ack_all();
    for (int k = 0; k < 3; k++) ack[k] = 1'b1;
    @(posedge clock); #1;
    for (int k = 0; k < 3; k++) begin
      ack[k]   = 1'b0;
      mdl[k].v = 1'b0;
      check_eq($sformatf("ack_valid[%0d]", k), valid[k], 0);
      check_eq($sformatf("ack_qout[%0d]", k), qout[k], mdl[k].q);
    end
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s_qout[%0d]", tag, k), qout[k], mdl[k].q);
      check_eq($sformatf("%s_valid[%0d]", tag, k), valid[k], mdl[k].v);
      check_eq($sformatf("%s_co[%0d]", tag, k), co[k], 0);
      check_eq($sformatf("%s_busy[%0d]", tag, k), busy[k], 0);
      check_eq($sformatf("%s_fe[%0d]", tag, k), fe[k], mdl[k].fe);
      check_eq($sformatf("%s_pe[%0d]", tag, k), pe[k], mdl[k].pe);
      check_eq($sformatf("%s_ov[%0d]", tag, k), ov[k], mdl[k].ov);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b0; ser[k] = 1'b1; ack[k] = 1'b0; co_prev[k] = 1'b0;
      mdl[k] = '0;
    end
    repeat (3) @(posedge clock);
    #1;
    check_state("reset");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    send_all(8'hB2, 1'b0, 1'b1, 1'b0, 0);   // good frame
    ack_all();
    send_all(8'hB2, 1'b0, 1'b0, 1'b0, 0);   // stop bit low: framing error
    send_all(8'h0B, 1'b0, 1'b1, 1'b0, 0);   // good, correct parity
    ack_all();
    send_all(8'h0B, 1'b1, 1'b1, 1'b0, 0);   // wrong parity bit
    ack_all();
    send_all(8'hB2, 1'b0, 1'b1, 1'b0, 0);   // fill the slot
    send_all(8'h0B, 1'b0, 1'b1, 1'b1, 0);   // ack on the stop tick: new word loads
    send_all(8'h5A, 1'b0, 1'b1, 1'b0, 0);   // slot full: overrun, word dropped
    ack_all();

    // Partial frame with enable gaps, then asynchronous reset between edges.
    fork
      send_one(0, 8'h3C, 1'b0, 1'b1, 1'b0, 2, 5);
      send_one(1, 8'h3C, 1'b0, 1'b1, 1'b0, 2, 5);
      send_one(2, 8'h3C, 1'b0, 1'b1, 1'b0, 2, 5);
    join
    #2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) mdl[k] = '0;
    #1;
    check_state("rst_mid");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check_state("post_rst");

    send_all(8'hA5, 1'b0, 1'b1, 1'b0, 2);   // enable every third cycle
    ack_all();
    send_all(8'h5A, 1'b0, 1'b1, 1'b0, 0);   // back-to-back pair, no ack between
    send_all(8'hC3, 1'b0, 1'b1, 1'b0, 0);
    repeat (2) @(posedge clock);
    #1;
    ack_all();
    repeat (3) @(posedge clock);
    #1;

    check_eq("sb0_drained", sb0.size(), 0);
    check_eq("sb1_drained", sb1.size(), 0);
    check_eq("sb2_drained", sb2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
Downstream partner of the parallel-to-serial transmitter. It samples a framed serial line on enable ticks, reassembles WIDTH-bit words, and checks start, parity and stop bits. The assembled word is presented on qout with a valid/ack hold-until-consumed handshake, and errors are reported as flags. It sits between the serial link and the parallel consumer, such as a register file or display logic.

Parameters:
WIDTH, 8, data bits per frame
MSB_FIRST, 1, 1 = first data bit received is qout[WIDTH-1]; 0 = first data bit received is qout[0]
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  bit tick; line is sampled only on clock edges where enable = 1
serialin  input  1  serial line; idles high
ack  input  1  consumer accepts qout; sampled only while valid = 1
qout  output  WIDTH  last good received word
valid  output  1  qout holds an unconsumed word
co  output  1  one-cycle pulse on every completed frame, good or bad
busy  output  1  high in any state other than IDLE
frame_err  output  1  sticky: stop bit sampled as 0
parity_err  output  1  sticky: parity mismatch
overrun  output  1  sticky: good frame finished while valid = 1

Behaviour:
- Reset (async, any state, mid-frame included): state = IDLE, shift register = 0, bit counter = 0; qout = 0; valid, co, busy, frame_err, parity_err and overrun all = 0. Any partial frame is discarded.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions happen only on edges with enable = 1, except the handshake and co logic, which run every cycle.
- IDLE: on a tick with serialin = 0 (start bit), go to DATA with counter = 0. serialin = 1 stays in IDLE.
- DATA: each tick shifts serialin into the shift register and increments the counter.
  - MSB_FIRST = 1: shift left, new bit enters the LSB.
  - MSB_FIRST = 0: shift right, new bit enters the MSB.
  - On the tick where counter = WIDTH-1: go to PARITY if PARITY_EN = 1, else STOP.
- PARITY: on the tick, compare the XOR of the data bits and the parity bit.
  - Even parity requires the result 0; odd parity requires 1.
  - A mismatch sets an internal bad flag for this frame. Go to STOP.
- STOP: on the tick, sample serialin and return to IDLE. co = 1 for exactly the following clock cycle.
  - serialin = 0: frame_err <= 1; frame bad.
  - Parity bad: parity_err <= 1.
  - Good frame with valid = 0: qout <= shift register, valid <= 1.
  - Good frame with valid = 1: overrun <= 1; qout unchanged; new word dropped.
  - Bad frame: qout and valid unchanged.
- Handshake: valid clears on the edge where valid = 1 and ack = 1.
  - Same edge as a good-frame completion: the clear wins first, so the new word loads and valid stays 1 with no overrun.
- No timeout. Enable gaps of any length stall the FSM in place.
- Latency: the valid rise and the co pulse are registered outputs, both visible in the cycle after the stop-bit tick.
- A start bit is accepted on the first tick after STOP. Back-to-back frames need no idle ticks.
- Error flags clear only on reset.

Decomposition:
- Shared package: state encoding (IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3) and the default WIDTH constant. The transmitter uses the same package so both ends agree on the frame format.
- One sub-module is natural: serial_shift_in. It holds the WIDTH-bit shift register and bit counter, with inputs shift_en, clr, bit_in, and outputs word and last_bit. The FSM, parity check and handshake stay in the top.

Test Plan:
- Good frame: enable = 1 constantly, defaults. Line 0, 10110010 (MSB first), 1 → after the stop tick, qout = 8'hB2, valid = 1, co high for one cycle, all error flags = 0.
- Framing error: same frame with stop bit = 0 → co pulses, frame_err = 1, valid stays 0, qout unchanged.
- Parity: PARITY_EN = 1, even. Frame 0, 00001011, parity 1, stop 1 → qout = 8'h0B, parity_err = 0. Repeat with parity bit 0 → parity_err = 1, valid stays 0.
- Overrun: receive 8'hB2 without ack, then 8'h0B → overrun = 1, qout stays 8'hB2. Then pulse ack → valid = 0.
- Handshake race: assert ack on the same edge as the stop tick of 8'h0B → qout = 8'h0B, valid = 1, overrun = 0.
- Reset mid-frame plus enable gaps: enable toggles every third cycle. Assert reset after 4 data bits → all outputs 0, state IDLE. Next full frame 8'hA5 → qout = 8'hA5.
